// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song playback path: the sequencer state type,
// default timing constants for a 50 MHz clock, and the song length shared
// with the melody/harmony note players so that beat ranges agree.
// ---------------------------------------------------------------------------
package song_pkg;

  // Playback state of the beat sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of beat indices in the song (indices 0..SONG_LEN-1).
  localparam int SONG_LEN = 168;

  // Default timing: eighth note at 120 bpm from a 50 MHz clock.
  localparam int BEAT_TICKS_DEFAULT = 12_500_000;
  localparam int TEMPO_STEP_DEFAULT = 500_000;
  localparam int GAP_TICKS_DEFAULT  = 1_250_000;
  localparam int CNT_W_DEFAULT      = 25;

  // Width of the beat index bus.
  localparam int BEAT_W = 8;

  // Beat period in clocks for a given tempo select.
  function automatic int beat_period(input int beat_ticks,
                                     input int tempo_step,
                                     input logic [3:0] tempo);
    return beat_ticks - (int'({28'd0, tempo}) * tempo_step);
  endfunction

endpackage

// File: rtl/song_beat_sequencer_if.sv
// ---------------------------------------------------------------------------
// song_beat_sequencer_if
// Control and status bundle of the beat sequencer.
//   play/pause/stop : single-cycle key pulses from the debouncers
//   loop_en         : level, wrap at song end instead of finishing
//   tempo           : 4-bit tempo select, larger is faster
//   beats           : current beat index to the note players
//   beat_strobe     : one-cycle pulse on the first cycle of each beat
//   note_gate       : high while the current note should sound
//   playing / done  : state flags
// master drives the controls; slave is the sequencer side.
// ---------------------------------------------------------------------------
interface song_beat_sequencer_if;
  logic       play;
  logic       pause;
  logic       stop;
  logic       loop_en;
  logic [3:0] tempo;
  logic [7:0] beats;
  logic       beat_strobe;
  logic       note_gate;
  logic       playing;
  logic       done;

  modport master (
    output play, pause, stop, loop_en, tempo,
    input  beats, beat_strobe, note_gate, playing, done
  );

  modport slave (
    input  play, pause, stop, loop_en, tempo,
    output beats, beat_strobe, note_gate, playing, done
  );
endinterface

// File: rtl/song_beat_sequencer_beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer
// Tick counter for one beat, the latched beat period, end-of-beat detection
// and the registered articulation gate.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the tick counter this cycle
//   restart    : start a new beat (tick 0, latch period from tempo)
//   clear      : return the tick counter to 0 without latching a period
//   active     : the sequencer will be in PLAY next cycle
//   tempo      : tempo select used when a period is latched
//   beat_end   : current tick is the last tick of the beat
//   gate       : registered note gate
// ---------------------------------------------------------------------------
module beat_timer #(
  parameter int BEAT_TICKS = song_pkg::BEAT_TICKS_DEFAULT,
  parameter int TEMPO_STEP = song_pkg::TEMPO_STEP_DEFAULT,
  parameter int GAP_TICKS  = song_pkg::GAP_TICKS_DEFAULT,
  parameter int CNT_W      = song_pkg::CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  input  logic       clear,
  input  logic       active,
  input  logic [3:0] tempo,
  output logic       beat_end,
  output logic       gate
);
  import song_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] BEAT_CNT = CNT_W'(BEAT_TICKS);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] new_period_s;
  logic             gate_q, gate_d;

  assign new_period_s = CNT_W'(beat_period(BEAT_TICKS, TEMPO_STEP, tempo));

  // Last tick of the beat, compared against the period latched at beat start.
  assign beat_end = (tick_q == (period_q - CNT_ONE));
  assign gate     = gate_q;

  // Next tick/period; the gate looks at the next-cycle values so that it
  // rises together with beat_strobe.
  always_comb begin
    tick_d   = tick_q;
    period_d = period_q;
    if (clear) begin
      tick_d = CNT_ZERO;
    end else if (restart) begin
      tick_d   = CNT_ZERO;
      period_d = new_period_s;
    end else if (run) begin
      tick_d = tick_q + CNT_ONE;
    end else begin
      tick_d = tick_q;
    end
    gate_d = active && (tick_d < (period_d - GAP_CNT));
  end

  // Counter, period latch and gate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= CNT_ZERO;
      period_q <= BEAT_CNT;
      gate_q   <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      period_q <= period_d;
      gate_q   <= gate_d;
    end
  end

endmodule

// File: rtl/song_beat_sequencer.sv
// ---------------------------------------------------------------------------
// song_beat_sequencer
// Tempo-driven beat counter feeding the melody/harmony note players.
// Turns play/pause/stop key pulses into IDLE/PLAY/PAUSE/DONE playback,
// counts beat indices 0..SONG_LEN-1, and emits a per-beat strobe plus an
// articulation gate that drops for the last GAP_TICKS clocks of each beat.
//   CLOCK_50 : system clock
//   rst_n    : asynchronous active-low reset
//   sif      : control/status bundle (slave side), all outputs registered
// ---------------------------------------------------------------------------
module song_beat_sequencer #(
  parameter int SONG_LEN   = song_pkg::SONG_LEN,
  parameter int BEAT_TICKS = song_pkg::BEAT_TICKS_DEFAULT,
  parameter int TEMPO_STEP = song_pkg::TEMPO_STEP_DEFAULT,
  parameter int GAP_TICKS  = song_pkg::GAP_TICKS_DEFAULT,
  parameter int CNT_W      = song_pkg::CNT_W_DEFAULT
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  song_beat_sequencer_if.slave  sif
);
  import song_pkg::*;

  localparam logic [7:0] LAST_BEAT = 8'(SONG_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] beats_q, beats_d;
  logic       strobe_q, strobe_d;
  logic       playing_q, playing_d;
  logic       done_q, done_d;

  logic       run_s;
  logic       restart_s;
  logic       clear_s;
  logic       active_s;
  logic       beat_end_s;
  logic       gate_s;

  beat_timer #(
    .BEAT_TICKS (BEAT_TICKS),
    .TEMPO_STEP (TEMPO_STEP),
    .GAP_TICKS  (GAP_TICKS),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (CLOCK_50),
    .rst_n    (rst_n),
    .run      (run_s),
    .restart  (restart_s),
    .clear    (clear_s),
    .active   (active_s),
    .tempo    (sif.tempo),
    .beat_end (beat_end_s),
    .gate     (gate_s)
  );

  // Next-state, beat index and timer control; stop beats pause beats play.
  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    strobe_d  = 1'b0;
    run_s     = 1'b0;
    restart_s = 1'b0;
    clear_s   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (sif.stop) begin
          state_d = IDLE;
          beats_d = 8'd0;
          clear_s = 1'b1;
        end else if (sif.play) begin
          state_d   = PLAY;
          beats_d   = 8'd0;
          restart_s = 1'b1;
          strobe_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      PLAY: begin
        if (sif.stop) begin
          state_d = IDLE;
          beats_d = 8'd0;
          clear_s = 1'b1;
        end else if (sif.pause) begin
          // Counter is simply not advanced, freezing the beat position.
          state_d = PAUSE;
        end else if (beat_end_s) begin
          if (beats_q < LAST_BEAT) begin
            beats_d   = beats_q + 8'd1;
            restart_s = 1'b1;
            strobe_d  = 1'b1;
          end else if (sif.loop_en) begin
            beats_d   = 8'd0;
            restart_s = 1'b1;
            strobe_d  = 1'b1;
          end else begin
            // Song finished: beats keeps pointing at the last index.
            state_d = DONE;
          end
        end else begin
          run_s = 1'b1;
        end
      end
      PAUSE: begin
        if (sif.stop) begin
          state_d = IDLE;
          beats_d = 8'd0;
          clear_s = 1'b1;
        end else if (sif.play) begin
          // Resume from the frozen tick: no advance and no strobe this edge.
          state_d = PLAY;
        end else begin
          state_d = PAUSE;
        end
      end
      default: begin
        state_d = IDLE;
        beats_d = 8'd0;
        clear_s = 1'b1;
      end
    endcase
    active_s  = (state_d == PLAY);
    playing_d = (state_d == PLAY);
    done_d    = (state_d == DONE);
  end

  // State, beat index and status flag registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beats_q   <= 8'd0;
      strobe_q  <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      strobe_q  <= strobe_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign sif.beats       = beats_q;
  assign sif.beat_strobe = strobe_q;
  assign sif.note_gate   = gate_s;
  assign sif.playing     = playing_q;
  assign sif.done        = done_q;

endmodule

// File: tb/tb_song_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_beat_sequencer
// Self-checking bench for song_beat_sequencer with BEAT_TICKS=10,
// TEMPO_STEP=1, GAP_TICKS=2, SONG_LEN=4. Directed scenarios use expected
// values derived from cycle arithmetic; a randomized run is checked against
// a beat-position reference model.
// Observed vector layout: {beats[7:0], beat_strobe, note_gate, playing, done}
// ---------------------------------------------------------------------------
module tb_song_beat_sequencer;

  localparam int T_SONG = 4;
  localparam int T_BEAT = 10;
  localparam int T_STEP = 1;
  localparam int T_GAP  = 2;

  localparam int M_STOPPED = 0;
  localparam int M_RUN     = 1;
  localparam int M_HELD    = 2;
  localparam int M_FIN     = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: playback mode, beat index, position in beat, beat length.
  int m_mode, m_beat, m_pos, m_len;

  always #5 clk = ~clk;

  song_beat_sequencer_if sif();

  song_beat_sequencer #(
    .SONG_LEN   (T_SONG),
    .BEAT_TICKS (T_BEAT),
    .TEMPO_STEP (T_STEP),
    .GAP_TICKS  (T_GAP),
    .CNT_W      (8)
  ) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .sif      (sif)
  );

  function automatic logic [11:0] observe();
    return {sif.beats, sif.beat_strobe, sif.note_gate, sif.playing, sif.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sif.play  = 1'b0;
    sif.pause = 1'b0;
    sif.stop  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    sif.loop_en = 1'b0;
    sif.tempo   = 4'd0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_play();
    sif.play = 1'b1;
    step();
    sif.play = 1'b0;
  endtask

  // Advance the reference model by one clock with the given inputs.
  task automatic m_step(input bit p, input bit pa, input bit s, input bit lp,
                        input int tmp, output logic [11:0] e);
    bit strobe;
    strobe = 1'b0;
    if (s) begin
      m_mode = M_STOPPED; m_beat = 0; m_pos = 0;
    end else if (m_mode == M_STOPPED || m_mode == M_FIN) begin
      if (p) begin
        m_mode = M_RUN; m_beat = 0; m_pos = 0;
        m_len = T_BEAT - tmp * T_STEP; strobe = 1'b1;
      end
    end else if (m_mode == M_RUN) begin
      if (pa) begin
        m_mode = M_HELD;
      end else if (m_pos == m_len - 1) begin
        if (m_beat < T_SONG - 1 || lp) begin
          m_beat = (m_beat + 1) % T_SONG; m_pos = 0;
          m_len = T_BEAT - tmp * T_STEP; strobe = 1'b1;
        end else begin
          m_mode = M_FIN;
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end else begin
      if (p) m_mode = M_RUN;
    end
    e = {8'(m_beat), strobe, (m_mode == M_RUN) && (m_pos < m_len - T_GAP),
         m_mode == M_RUN, m_mode == M_FIN};
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst_n = 1'b0;
    idle_inputs();
    sif.loop_en = 1'b0;
    sif.tempo   = 4'd0;
    step();
    obs = observe();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held got=%h exp=%h", obs, 12'h000);
    end
    rst_n = 1'b1;
    repeat (3) step();
    obs = observe();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_released got=%h exp=%h", obs, 12'h000);
    end
  endtask

  task automatic test_play_to_done();
    logic [11:0] obs, exp;
    do_reset();
    pulse_play();
    for (int c = 1; c <= 46; c++) begin
      exp = {8'((c > 40) ? 3 : (c - 1) / 10),
             (c <= 31) && ((c - 1) % 10 == 0),
             (c <= 40) && ((c - 1) % 10 < 8),
             c <= 40, c > 40};
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL play_to_done cycle=%0d got=%h exp=%h", c, obs, exp);
      end
      // pause in DONE must be ignored
      sif.pause = (c == 43);
      step();
    end
    idle_inputs();
  endtask

  task automatic test_loop();
    logic [11:0] obs, exp;
    do_reset();
    sif.loop_en = 1'b1;
    pulse_play();
    for (int c = 1; c <= 52; c++) begin
      exp = {8'(((c - 1) / 10) % 4), (c - 1) % 10 == 0, (c - 1) % 10 < 8,
             1'b1, 1'b0};
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL loop cycle=%0d got=%h exp=%h", c, obs, exp);
      end
      // play while already playing must be ignored
      sif.play = (c == 24);
      step();
    end
    idle_inputs();
    sif.loop_en = 1'b0;
  endtask

  task automatic test_pause_resume();
    logic [11:0] obs, exp;
    do_reset();
    pulse_play();
    repeat (15) step();
    obs = observe();
    n_checks++;
    if (obs !== {8'd1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pause_pre got=%h exp=%h", obs, {8'd1, 4'b0110});
    end
    sif.pause = 1'b1;
    step();
    sif.pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      obs = observe();
      n_checks++;
      if (obs !== {8'd1, 4'b0000}) begin
        n_fail++;
        $display("FAIL paused i=%0d got=%h exp=%h", i, obs, {8'd1, 4'b0000});
      end
      sif.pause = (i == 5);
      sif.play  = (i == 19);
      step();
    end
    idle_inputs();
    for (int k = 0; k <= 5; k++) begin
      exp = {8'((k == 5) ? 2 : 1), k == 5, (k == 5) || (5 + k < 8), 1'b1, 1'b0};
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL resume k=%0d got=%h exp=%h", k, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_tempo_change();
    logic [11:0] obs, exp;
    do_reset();
    pulse_play();
    for (int c = 1; c <= 17; c++) begin
      exp = {8'((c < 11) ? 0 : ((c < 17) ? 1 : 2)),
             (c == 1) || (c == 11) || (c == 17),
             (c <= 8) || ((c >= 11) && (c <= 14)) || (c == 17),
             1'b1, 1'b0};
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL tempo cycle=%0d got=%h exp=%h", c, obs, exp);
      end
      if (c == 4) sif.tempo = 4'd4;
      step();
    end
    sif.tempo = 4'd0;
  endtask

  task automatic test_priority();
    logic [11:0] obs;
    do_reset();
    pulse_play();
    repeat (4) step();
    sif.stop = 1'b1; sif.pause = 1'b1; sif.play = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      obs = observe();
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL priority_stop i=%0d got=%h exp=%h", i, obs, 12'h000);
      end
      step();
    end
    pulse_play();
    obs = observe();
    n_checks++;
    if (obs !== {8'd0, 4'b1110}) begin
      n_fail++;
      $display("FAIL restart_after_stop got=%h exp=%h", obs, {8'd0, 4'b1110});
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] obs;
    do_reset();
    pulse_play();
    repeat (14) step();
    #2 rst_n = 1'b0;
    #1;
    obs = observe();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", obs, 12'h000);
    end
    step();
    rst_n = 1'b1;
    step();
    obs = observe();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL after_async_reset got=%h exp=%h", obs, 12'h000);
    end
  endtask

  task automatic test_random();
    logic [11:0] obs, exp;
    do_reset();
    m_mode = M_STOPPED; m_beat = 0; m_pos = 0; m_len = T_BEAT;
    for (int n = 0; n < 3000; n++) begin
      sif.play  = ($urandom_range(0, 7) == 0);
      sif.pause = ($urandom_range(0, 15) == 0);
      sif.stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) sif.loop_en = ~sif.loop_en;
      if ($urandom_range(0, 49) == 0) sif.tempo = 4'($urandom_range(0, 7));
      m_step(sif.play, sif.pause, sif.stop, sif.loop_en, int'(sif.tempo), exp);
      step();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random n=%0d got=%h exp=%h", n, obs, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    sif.loop_en = 1'b0;
    sif.tempo   = 4'd0;
    test_reset();
    test_play_to_done();
    test_loop();
    test_pause_resume();
    test_tempo_change();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
